piezo_tone_decoder: RTL and testbench
=====================================

Name: piezo_tone_decoder

Overview:
Receive-side counterpart of the piezo tone generator. Samples a square-wave tone line, such as the piezo drive pin looped back or a test stimulus, and measures its rising-edge-to-rising-edge period in clk cycles. Matches the period against the eight-note scale table (C4..C5) and reports the note in the same one-hot encoding as the 8-bit button bus. Used for self-test of the tone path and as a bench checker.

Parameters:
CNT_W, 16, width of period counter and period output
NOTE_P0, 3822, C4 period in clk cycles (1 MHz clk)
NOTE_P1, 3405, D4 period
NOTE_P2, 3034, E4 period
NOTE_P3, 2863, F4 period
NOTE_P4, 2551, G4 period
NOTE_P5, 2273, A4 period
NOTE_P6, 2025, B4 period
NOTE_P7, 1911, C5 period
TOL, 40, accepted absolute deviation in cycles, inclusive; 2*TOL must be less than the minimum table spacing of 114
TIMEOUT, 8000, cycles without a rising edge before silence is declared

Ports:
clk  in  1  system clock, 1 MHz nominal
rst  in  1  asynchronous, active-high reset
tone_in  in  1  asynchronous square-wave input
note_onehot  out  8  decoded note; bit i = NOTE_Pi; 0 = none
note_valid  out  1  high while note_onehot holds a confirmed note
note_strobe  out  1  one-cycle pulse whenever note_onehot changes value, including to 0
period  out  CNT_W  last measured edge-to-edge period in cycles

Behaviour:
- Reset, asynchronous and active-high: all outputs 0, synchronizer flops 0, counter 0, state IDLE.
- tone_in passes through a 2-flop synchronizer and then an edge register. A rising edge is detected 3 clk after the pin transition.
- Period counter: on a detected edge, period <= count of cycles since the previous detected edge, then the counter restarts. The counter saturates at all-ones and never wraps. period updates on every edge after the first, whether or not it matches a note.
- Match: index i when |period - NOTE_Pi| <= TOL. At most one index can match. Otherwise the result is no-match.
- Timeout: when the counter reaches TIMEOUT with no edge, go to IDLE from any state.
- States:
  - IDLE: on the first edge, go to ARMED. No period is reported from the IDLE edge.
  - ARMED: on an edge with match i, set cand=i and go to CONFIRM. On an edge with no match, stay in ARMED.
  - CONFIRM: on an edge matching cand, go to TRACK. On an edge matching j != cand, set cand=j and stay. On an edge with no match, go to ARMED.
  - TRACK: on an edge matching cand, stay. On an edge matching j != cand, set cand=j, clear outputs, go to CONFIRM. On an edge with no match, clear outputs and go to ARMED.
- Entering TRACK sets note_onehot=1<<cand and note_valid=1, both registered 1 clk after the detection cycle. The first valid note therefore needs three input rising edges, i.e. two consecutive matching periods.
- Leaving TRACK (mismatch or timeout) clears note_onehot and note_valid 1 clk after the cause.
- note_strobe pulses high for exactly 1 clk, coincident with every change of note_onehot. It never pulses on a no-change cycle.
- Reset asserted mid-measurement aborts immediately. After release, the decoder restarts from IDLE and needs three edges again.
- A DC-high or DC-low input produces no edges and leads to timeout, giving all outputs 0.

Test Plan:
- Reset, then a 3822-cycle square wave (50% duty) -> note_onehot=8'b00000001, note_valid=1, period=3822, one note_strobe, all within 4 clk of the 3rd rising edge; nothing before that edge.
- 3405-cycle tone held, then switched to 2273 -> D4 sets 8'b00000010. On the first 2273 period the outputs clear to 0 with a strobe. On the second 2273 period the outputs become 8'b00100000 with a strobe.
- Periods 2233 and 2313 (A4 ± TOL) -> accepted as 8'b00100000. Periods 2232 and 2314 -> no-match, outputs stay 0, period still updates.
- Valid C5 tone, then tone_in held low -> outputs clear to 0 with a strobe exactly TIMEOUT cycles after the last edge, plus 1 clk. A later tone needs three edges to revalidate.
- Out-of-table period of 3200 -> period=3200, note_valid never asserts, no strobes.
- rst pulse mid-TRACK on a G4 tone -> outputs 0 immediately and asynchronously. After release, outputs return to 8'b00010000 on the 3rd following edge.

Source files
------------

// File: rtl/piezo_tone_decoder.sv
// Tone-line period meter and note matcher: measures rising-edge spacing of a
// square wave and reports the C4..C5 note once two consecutive periods agree.
module piezo_tone_decoder #(
  parameter int CNT_W   = 16,
  parameter int NOTE_P0 = 3822,
  parameter int NOTE_P1 = 3405,
  parameter int NOTE_P2 = 3034,
  parameter int NOTE_P3 = 2863,
  parameter int NOTE_P4 = 2551,
  parameter int NOTE_P5 = 2273,
  parameter int NOTE_P6 = 2025,
  parameter int NOTE_P7 = 1911,
  parameter int TOL     = 40,
  parameter int TIMEOUT = 8000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [7:0]       note_onehot,
  output logic             note_valid,
  output logic             note_strobe,
  output logic [CNT_W-1:0] period
);
  // state     | meaning
  // S_IDLE    | no edge seen since reset or timeout
  // S_ARMED   | edge reference held, waiting for a matching period
  // S_CONFIRM | one matching period seen for r_cand
  // S_TRACK   | r_cand confirmed and reported
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CONFIRM, S_TRACK} state_t;

  localparam int NOTE_TAB [8] = '{NOTE_P0, NOTE_P1, NOTE_P2, NOTE_P3,
                                  NOTE_P4, NOTE_P5, NOTE_P6, NOTE_P7};
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2, r_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cand, w_cand_nxt;
  logic             w_rise, w_timeout, w_hit;
  logic [2:0]       w_hit_idx;
  logic [7:0]       w_note_nxt;
  logic             w_valid_nxt;

  assign w_rise    = r_sync2 & ~r_edge;
  assign w_timeout = ~w_rise & (r_cnt == TIMEOUT_CNT);

  // r_cnt holds the cycles elapsed since the previous edge in the edge cycle itself
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if ((int'(r_cnt) >= NOTE_TAB[i] - TOL) && (int'(r_cnt) <= NOTE_TAB[i] + TOL)) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
      r_cnt   <= '0;
      period  <= '0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
        if (r_state != S_IDLE) period <= r_cnt;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      note_onehot <= '0;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      note_onehot <= w_note_nxt;
      note_valid  <= w_valid_nxt;
      note_strobe <= (w_note_nxt != note_onehot);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_rise) begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_hit) begin
            w_cand_nxt  = w_hit_idx;
            w_state_nxt = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (!w_hit)                   w_state_nxt = S_ARMED;
          else if (w_hit_idx == r_cand) w_state_nxt = S_TRACK;
          else                          w_cand_nxt  = w_hit_idx;
        end
        S_TRACK: begin
          if (!w_hit) begin
            w_state_nxt = S_ARMED;
          end else if (w_hit_idx != r_cand) begin
            w_cand_nxt  = w_hit_idx;
            w_state_nxt = S_CONFIRM;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_note_nxt  = '0;
    w_valid_nxt = 1'b0;
    if (w_state_nxt == S_TRACK) begin
      w_note_nxt  = 8'b1 << w_cand_nxt;
      w_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Bench for piezo_tone_decoder: square-wave stimulus scored against a model that
// reports a note whenever the last two measured periods match the same table entry.
module tb_piezo_tone_decoder;
  localparam int CNT_W   = 16;
  localparam int TOL     = 40;
  localparam int TIMEOUT = 8000;
  localparam int SETTLE  = 6;
  localparam int TAB [8] = '{3822, 3405, 3034, 2863, 2551, 2273, 2025, 1911};

  logic             clk = 1'b0, rst = 1'b0, tone_in = 1'b0;
  logic [7:0]       note_onehot;
  logic             note_valid, note_strobe;
  logic [CNT_W-1:0] period;

  piezo_tone_decoder #(
    .CNT_W(CNT_W), .NOTE_P0(TAB[0]), .NOTE_P1(TAB[1]), .NOTE_P2(TAB[2]),
    .NOTE_P3(TAB[3]), .NOTE_P4(TAB[4]), .NOTE_P5(TAB[5]), .NOTE_P6(TAB[6]),
    .NOTE_P7(TAB[7]), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in), .note_onehot(note_onehot),
    .note_valid(note_valid), .note_strobe(note_strobe), .period(period)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int chg_cnt = 0, strobe_cnt = 0, strobe_err = 0, last_chg_cyc = 0;
  logic [7:0] mon_prev = '0;

  always @(posedge clk) cyc++;

  // strobe must coincide exactly with every change of the note bus
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = note_onehot;
    end else begin
      if (note_strobe) strobe_cnt++;
      if (note_strobe !== (note_onehot !== mon_prev)) strobe_err++;
      if (note_onehot !== mon_prev) begin
        chg_cnt++;
        last_chg_cyc = cyc;
      end
      mon_prev = note_onehot;
    end
  end

  // reference model
  int m_edges, m_last, m_prev, exp_period;
  logic [7:0] exp_note, prev_note;
  int rise_cyc, sb;

  function automatic int ref_match(input int p);
    for (int i = 0; i < 8; i++) begin
      int d = p - TAB[i];
      if (d < 0) d = -d;
      if (d <= TOL) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_edges = 0; m_last = -1; m_prev = -1; exp_note = '0;
  endtask

  task automatic model_edge(input int gap);
    if (m_edges > 0) begin
      exp_period = gap;
      m_prev     = m_last;
      m_last     = ref_match(gap);
    end
    m_edges++;
    exp_note = (m_edges >= 3 && m_last >= 0 && m_last == m_prev) ? 8'(1 << m_last) : 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    tone_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_period = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic edge_in(input int gap);
    tone_in   = 1'b1;
    rise_cyc  = cyc;
    sb        = strobe_cnt;
    prev_note = exp_note;
    model_edge(gap);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic edge_rest(input int p, input int hi);
    repeat (hi - SETTLE) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - hi) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (note_onehot !== 8'h00) begin bad++; $display("FAIL reset_note got=%b exp=0", note_onehot); end
    total++; if (note_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", note_valid); end
    total++; if (note_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", note_strobe); end
    total++; if (period !== '0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
  endtask

  task automatic test_c4();
    int g[$] = '{0, 3822, 3822};
    int c0, set_delay;
    do_reset();
    c0 = chg_cnt;
    for (int k = 0; k < g.size(); k++) begin
      if (k == 2) begin
        total++; if (chg_cnt != c0) begin bad++; $display("FAIL c4_early_change got=%0d exp=0", chg_cnt - c0); end
      end
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL c4_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      total++; if (note_valid !== (exp_note != 0)) begin bad++; $display("FAIL c4_valid edge=%0d got=%b", k, note_valid); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL c4_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      total++; if (strobe_cnt - sb != int'(exp_note != prev_note)) begin bad++; $display("FAIL c4_strobe edge=%0d got=%0d", k, strobe_cnt - sb); end
      if (k + 1 < g.size()) edge_rest(g[k+1], g[k+1] / 2);
    end
    set_delay = last_chg_cyc - rise_cyc;
    total++; if (set_delay < 1 || set_delay > 4) begin bad++; $display("FAIL c4_latency got=%0d exp=1..4", set_delay); end
    total++; if (note_onehot !== 8'b00000001) begin bad++; $display("FAIL c4_final got=%b exp=00000001", note_onehot); end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_switch();
    int g[$] = '{0, 3405, 3405, 2273, 2273};
    do_reset();
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL sw_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      total++; if (note_valid !== (exp_note != 0)) begin bad++; $display("FAIL sw_valid edge=%0d got=%b", k, note_valid); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL sw_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      total++; if (strobe_cnt - sb != int'(exp_note != prev_note)) begin bad++; $display("FAIL sw_strobe edge=%0d got=%0d", k, strobe_cnt - sb); end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    total++; if (note_onehot !== 8'b00100000) begin bad++; $display("FAIL sw_final got=%b exp=00100000", note_onehot); end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_tolerance();
    int g[$] = '{0, 2233, 2313, 2232, 2314};
    do_reset();
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL tol_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      total++; if (note_valid !== (exp_note != 0)) begin bad++; $display("FAIL tol_valid edge=%0d got=%b", k, note_valid); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL tol_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      total++; if (strobe_cnt - sb != int'(exp_note != prev_note)) begin bad++; $display("FAIL tol_strobe edge=%0d got=%0d", k, strobe_cnt - sb); end
      if (k == 2) begin
        total++; if (note_onehot !== 8'b00100000) begin bad++; $display("FAIL tol_accept got=%b exp=00100000", note_onehot); end
      end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_timeout();
    int g[$] = '{0, 1911, 1911};
    int set_delay, waited;
    do_reset();
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL to_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      if (k + 1 < g.size()) edge_rest(g[k+1], g[k+1] / 2);
    end
    set_delay = last_chg_cyc - rise_cyc;
    sb = strobe_cnt;
    edge_rest(SETTLE + 4, SETTLE + 2);
    waited = 0;
    while (note_onehot !== 8'h00 && waited < TIMEOUT + 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    model_clear();
    total++; if (note_onehot !== 8'h00 || note_valid !== 1'b0) begin bad++; $display("FAIL to_clear got=%b/%b exp=0/0", note_onehot, note_valid); end
    total++; if (last_chg_cyc - rise_cyc != set_delay + TIMEOUT) begin bad++; $display("FAIL to_delay got=%0d exp=%0d", last_chg_cyc - rise_cyc, set_delay + TIMEOUT); end
    total++; if (strobe_cnt - sb != 1) begin bad++; $display("FAIL to_strobe got=%0d exp=1", strobe_cnt - sb); end
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL to_re_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL to_re_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    total++; if (note_onehot !== 8'b10000000) begin bad++; $display("FAIL to_revalid got=%b exp=10000000", note_onehot); end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_out_of_table();
    int g[$] = '{0, 3200, 3200};
    do_reset();
    sb = strobe_cnt;
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_valid !== 1'b0) begin bad++; $display("FAIL oot_valid edge=%0d got=%b exp=0", k, note_valid); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL oot_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    total++; if (period !== 16'd3200) begin bad++; $display("FAIL oot_final_period got=%0d exp=3200", period); end
    edge_rest(SETTLE + 4, SETTLE + 2);
    total++; if (strobe_cnt != sb) begin bad++; $display("FAIL oot_strobes got=%0d exp=0", strobe_cnt - sb); end
  endtask

  task automatic test_reset_mid_track();
    int g[$] = '{0, 2551, 2551};
    do_reset();
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      if (k + 1 < g.size()) edge_rest(g[k+1], g[k+1] / 2);
    end
    total++; if (note_onehot !== 8'b00010000) begin bad++; $display("FAIL rst_pre got=%b exp=00010000", note_onehot); end
    edge_rest(SETTLE + 40, SETTLE + 2);
    #2 rst = 1'b1;
    #1;
    total++; if (note_onehot !== 8'h00) begin bad++; $display("FAIL rst_async_note got=%b exp=0", note_onehot); end
    total++; if (note_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", note_valid); end
    total++; if (period !== '0) begin bad++; $display("FAIL rst_async_period got=%0d exp=0", period); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_period = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL rst_re_note edge=%0d got=%b exp=%b", k, note_onehot, exp_note); end
      total++; if (note_valid !== (exp_note != 0)) begin bad++; $display("FAIL rst_re_valid edge=%0d got=%b", k, note_valid); end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    total++; if (note_onehot !== 8'b00010000) begin bad++; $display("FAIL rst_final got=%b exp=00010000", note_onehot); end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_random();
    int g[$];
    int idx, off;
    do_reset();
    g.push_back(0);
    for (int k = 1; k < 7; k++) begin
      if (k > 1 && $urandom_range(0, 2) != 0) begin
        g.push_back(g[k-1] + int'($urandom_range(0, 2 * TOL)) - TOL);
      end else begin
        idx = $urandom_range(4, 7);
        off = int'($urandom_range(0, 2 * TOL + 20)) - (TOL + 10);
        g.push_back(TAB[idx] + off);
      end
    end
    for (int k = 0; k < g.size(); k++) begin
      edge_in(g[k]);
      total++; if (note_onehot !== exp_note) begin bad++; $display("FAIL rnd_note edge=%0d gap=%0d got=%b exp=%b", k, g[k], note_onehot, exp_note); end
      total++; if (note_valid !== (exp_note != 0)) begin bad++; $display("FAIL rnd_valid edge=%0d got=%b", k, note_valid); end
      total++; if (period !== 16'(exp_period)) begin bad++; $display("FAIL rnd_period edge=%0d got=%0d exp=%0d", k, period, exp_period); end
      total++; if (strobe_cnt - sb != int'(exp_note != prev_note)) begin bad++; $display("FAIL rnd_strobe edge=%0d got=%0d", k, strobe_cnt - sb); end
      if (k + 1 < g.size()) edge_rest(g[k+1], $urandom_range(g[k+1] / 4, 3 * g[k+1] / 4));
    end
    edge_rest(SETTLE + 4, SETTLE + 2);
  endtask

  task automatic test_strobe_alignment();
    total++; if (strobe_err != 0) begin bad++; $display("FAIL strobe_align got=%0d exp=0", strobe_err); end
  endtask

  initial begin
    model_clear();
    exp_period = 0;
    test_reset();
    test_c4();
    test_switch();
    test_tolerance();
    test_timeout();
    test_out_of_table();
    test_reset_mid_track();
    test_random();
    test_strobe_alignment();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
